// File: rtl/rtc_bus_controller_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller.
// Holds the FSM state encoding, default phase timings and RTC register addresses.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        GAP,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        RECOV
    } state_t;

    localparam int T_SETUP_DEF = 1;
    localparam int T_PULSE_DEF = 6;
    localparam int T_HOLD_DEF  = 1;
    localparam int T_GAP_DEF   = 11;
    localparam int T_RECOV_DEF = 10;

    localparam logic [7:0] REG_SECONDS = 8'h21;
    localparam logic [7:0] REG_MINUTES = 8'h22;
    localparam logic [7:0] REG_HOURS   = 8'h23;
    localparam logic [7:0] REG_CONTROL = 8'h02;

    function automatic logic is_addr_phase(input state_t s);
        return (s == A_SETUP) || (s == A_STROBE) || (s == A_HOLD);
    endfunction

    function automatic logic is_data_phase(input state_t s);
        return (s == D_SETUP) || (s == D_STROBE) || (s == D_HOLD);
    endfunction

endpackage

// File: rtl/rtc_bus_controller_if.sv
// Request/response handshake plus RTC bus pins for the RTC bus controller.
// Handshake: a request transfers on a clk edge where req_valid & req_ready; rsp_valid is a one-cycle pulse.
interface rtc_bus_controller_if;
    import rtc_bus_pkg::*;

    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;
    state_t     dbg_state;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, bus_in,
        output req_ready, rsp_valid, rsp_rdata, busy,
               cs_n, rd_n, wr_n, ad_n, bus_out, bus_oe, dbg_state
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, bus_in,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               cs_n, rd_n, wr_n, ad_n, bus_out, bus_oe, dbg_state
    );

endinterface

// File: rtl/rtc_bus_controller_phase_timer.sv
// Loadable 8-bit down-counter timing every FSM state; done marks the state's last cycle.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] cnt;

    // Loaded with N on state entry, so cnt reaches 1 in the Nth cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign done = (cnt == 8'd1);

endmodule

// File: rtl/rtc_bus_controller.sv
// Sequences one RTC bus transaction per request: timed address phase, gap, data phase, recovery.
module rtc_bus_controller
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int T_RECOV = T_RECOV_DEF
) (
    input logic           clk,
    input logic           reset_n,
    rtc_bus_controller_if.slave bus
);
    state_t     state, state_n;
    logic       load, done;
    logic [7:0] load_val;
    logic       lat_write;
    logic [7:0] lat_addr, lat_wdata;
    logic       txn_write;
    logic [7:0] txn_addr, txn_wdata;
    logic       cs_q, rd_q, wr_q, ad_q, oe_q, rsp_q, busy_q;
    logic [7:0] out_q, rdata_q;

    rtc_phase_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    // On the acceptance edge the latches are not yet written, so use the live request.
    assign txn_write = (state == IDLE) ? bus.req_write : lat_write;
    assign txn_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    assign txn_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        load_val = 8'd0;
        case (state)
            IDLE:     if (bus.req_valid) begin state_n = A_SETUP;  load = 1'b1; load_val = 8'(T_SETUP); end
            A_SETUP:  if (done)          begin state_n = A_STROBE; load = 1'b1; load_val = 8'(T_PULSE); end
            A_STROBE: if (done)          begin state_n = A_HOLD;   load = 1'b1; load_val = 8'(T_HOLD);  end
            A_HOLD:   if (done)          begin state_n = GAP;      load = 1'b1; load_val = 8'(T_GAP);   end
            GAP:      if (done)          begin state_n = D_SETUP;  load = 1'b1; load_val = 8'(T_SETUP); end
            D_SETUP:  if (done)          begin state_n = D_STROBE; load = 1'b1; load_val = 8'(T_PULSE); end
            D_STROBE: if (done)          begin state_n = D_HOLD;   load = 1'b1; load_val = 8'(T_HOLD);  end
            D_HOLD:   if (done)          begin state_n = RECOV;    load = 1'b1; load_val = 8'(T_RECOV); end
            RECOV:    if (done)          begin state_n = IDLE; end
            default:  state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            lat_addr  <= 8'd0;
            lat_wdata <= 8'd0;
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            ad_q      <= 1'b1;
            oe_q      <= 1'b0;
            out_q     <= 8'd0;
            rsp_q     <= 1'b0;
            rdata_q   <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.req_valid) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
            end
            cs_q   <= !(is_addr_phase(state_n) || is_data_phase(state_n));
            ad_q   <= !is_addr_phase(state_n);
            wr_q   <= !((state_n == A_STROBE) || (state_n == D_STROBE && txn_write));
            rd_q   <= !(state_n == D_STROBE && !txn_write);
            oe_q   <= is_addr_phase(state_n) || (is_data_phase(state_n) && txn_write);
            out_q  <= is_addr_phase(state_n) ? txn_addr :
                      (is_data_phase(state_n) && txn_write) ? txn_wdata : 8'd0;
            rsp_q  <= (state_n == RECOV) && (state != RECOV);
            busy_q <= (state_n != IDLE);
            if (state == D_STROBE && done && !lat_write) begin
                rdata_q <= bus.bus_in;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.dbg_state = state;
    assign bus.cs_n      = cs_q;
    assign bus.rd_n      = rd_q;
    assign bus.wr_n      = wr_q;
    assign bus.ad_n      = ad_q;
    assign bus.bus_oe    = oe_q;
    assign bus.bus_out   = out_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Directed bench for rtc_bus_controller: default-timing instance plus a short-timing instance.
module tb_rtc_bus_controller;
    import rtc_bus_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rtc_bus_controller_if bus_a ();
    rtc_bus_controller_if bus_b ();

    rtc_bus_controller u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a.slave)
    );

    rtc_bus_controller #(
        .T_SETUP (2),
        .T_PULSE (3),
        .T_HOLD  (1),
        .T_GAP   (1),
        .T_RECOV (1)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    logic       tr_cs[1:64], tr_rd[1:64], tr_wr[1:64], tr_ad[1:64];
    logic       tr_oe[1:64], tr_rv[1:64], tr_rdy[1:64], tr_busy[1:64];
    logic [7:0] tr_out[1:64], tr_rdata[1:64], tr_st[1:64];

    task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    task automatic set_req(input bit sel, input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        if (sel) begin
            bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a; bus_b.req_wdata = d;
        end else begin
            bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a; bus_a.req_wdata = d;
        end
    endtask

    task automatic set_bus_in(input logic [7:0] v);
        bus_a.bus_in = v;
        bus_b.bus_in = v;
    endtask

    task automatic grab(input bit sel, input int k);
        if (sel) begin
            tr_cs[k] = bus_b.cs_n; tr_rd[k] = bus_b.rd_n; tr_wr[k] = bus_b.wr_n; tr_ad[k] = bus_b.ad_n;
            tr_oe[k] = bus_b.bus_oe; tr_rv[k] = bus_b.rsp_valid; tr_rdy[k] = bus_b.req_ready;
            tr_busy[k] = bus_b.busy; tr_out[k] = bus_b.bus_out; tr_rdata[k] = bus_b.rsp_rdata;
            tr_st[k] = 8'(bus_b.dbg_state);
        end else begin
            tr_cs[k] = bus_a.cs_n; tr_rd[k] = bus_a.rd_n; tr_wr[k] = bus_a.wr_n; tr_ad[k] = bus_a.ad_n;
            tr_oe[k] = bus_a.bus_oe; tr_rv[k] = bus_a.rsp_valid; tr_rdy[k] = bus_a.req_ready;
            tr_busy[k] = bus_a.busy; tr_out[k] = bus_a.bus_out; tr_rdata[k] = bus_a.rsp_rdata;
            tr_st[k] = 8'(bus_a.dbg_state);
        end
    endtask

    // Issue one request, record cycles 1..ncyc relative to the acceptance edge.
    task automatic run_txn(input bit sel, input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rdval, input int ncyc, input bit hold,
                           input logic [7:0] a2, input int rst_at);
        @(negedge clk);
        set_req(sel, 1'b1, w, a, d);
        set_bus_in(8'hA5);
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            grab(sel, k);
            if (k == 1) begin
                if (hold) set_req(sel, 1'b1, w, a2, d);
                else      set_req(sel, 1'b0, w, ~a, ~d);
            end
            if (hold && k == 39) set_req(sel, 1'b0, w, a2, d);
            set_bus_in((k >= 21 && k <= 26) ? rdval : 8'hA5);
            if (rst_at != 0 && k == rst_at)     reset_n = 1'b0;
            if (rst_at != 0 && k == rst_at + 1) reset_n = 1'b1;
        end
    endtask

    task automatic check_default(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d,
                                 input logic [7:0] old_rd, input logic [7:0] new_rd, input int last);
        for (int k = 1; k <= last; k++) begin
            logic in_a, in_d, st_a, st_d;
            in_a = (k >= 1 && k <= 8);
            in_d = (k >= 20 && k <= 27);
            st_a = (k >= 2 && k <= 7);
            st_d = (k >= 21 && k <= 26);
            chk1({tag, ".cs_n"}, k, tr_cs[k], !(in_a || in_d));
            chk1({tag, ".ad_n"}, k, tr_ad[k], !in_a);
            chk1({tag, ".wr_n"}, k, tr_wr[k], w ? !(st_a || st_d) : !st_a);
            chk1({tag, ".rd_n"}, k, tr_rd[k], w ? 1'b1 : !st_d);
            chk1({tag, ".bus_oe"}, k, tr_oe[k], in_a || (w && in_d));
            chk1({tag, ".rsp_valid"}, k, tr_rv[k], k == 28);
            chk1({tag, ".busy"}, k, tr_busy[k], k <= 37);
            chk1({tag, ".req_ready"}, k, tr_rdy[k], k >= 38);
            if (in_a)      chk8({tag, ".bus_out"}, k, tr_out[k], a);
            if (w && in_d) chk8({tag, ".bus_out"}, k, tr_out[k], d);
            chk8({tag, ".rsp_rdata"}, k, tr_rdata[k], (!w && k >= 27) ? new_rd : old_rd);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int toggles;
        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_bus_in(8'h00);
        repeat (3) @(negedge clk);

        // Reset values
        chk1("rst.cs_n", 0, bus_a.cs_n, 1'b1);
        chk1("rst.rd_n", 0, bus_a.rd_n, 1'b1);
        chk1("rst.wr_n", 0, bus_a.wr_n, 1'b1);
        chk1("rst.ad_n", 0, bus_a.ad_n, 1'b1);
        chk1("rst.bus_oe", 0, bus_a.bus_oe, 1'b0);
        chk8("rst.bus_out", 0, bus_a.bus_out, 8'h00);
        chk1("rst.rsp_valid", 0, bus_a.rsp_valid, 1'b0);
        chk8("rst.rsp_rdata", 0, bus_a.rsp_rdata, 8'h00);
        chk1("rst.busy", 0, bus_a.busy, 1'b0);
        chk1("rst.req_ready", 0, bus_a.req_ready, 1'b1);
        chk8("rst.state", 0, 8'(bus_a.dbg_state), 8'(IDLE));
        reset_n = 1'b1;

        // Idle for 100 cycles: strobes and select stay high
        toggles = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (!bus_a.cs_n || !bus_a.rd_n || !bus_a.wr_n) toggles++;
            if (!bus_b.cs_n || !bus_b.rd_n || !bus_b.wr_n) toggles++;
        end
        chk8("idle.toggles", 100, 8'(toggles), 8'd0);
        chk1("idle.req_ready", 100, bus_a.req_ready, 1'b1);
        chk1("idle.busy", 100, bus_a.busy, 1'b0);

        // Write seconds register
        run_txn(1'b0, 1'b1, REG_SECONDS, 8'h45, 8'h00, 40, 1'b0, 8'h00, 0);
        check_default("wr1", 1'b1, REG_SECONDS, 8'h45, 8'h00, 8'h00, 40);
        chk8("wr1.state", 1, tr_st[1], 8'(A_SETUP));

        // Read minutes register
        run_txn(1'b0, 1'b0, REG_MINUTES, 8'h00, 8'h59, 40, 1'b0, 8'h00, 0);
        check_default("rd1", 1'b0, REG_MINUTES, 8'h00, 8'h00, 8'h59, 40);

        // Following write keeps the read data
        run_txn(1'b0, 1'b1, REG_HOURS, 8'h12, 8'h77, 40, 1'b0, 8'h00, 0);
        check_default("wr2", 1'b1, REG_HOURS, 8'h12, 8'h59, 8'h59, 40);

        // Back-to-back: second request held valid
        run_txn(1'b0, 1'b1, REG_CONTROL, 8'h80, 8'h00, 39, 1'b1, REG_SECONDS, 0);
        check_default("b2b", 1'b1, REG_CONTROL, 8'h80, 8'h59, 8'h59, 38);
        chk1("b2b.cs_n", 39, tr_cs[39], 1'b0);
        chk1("b2b.ad_n", 39, tr_ad[39], 1'b0);
        chk8("b2b.bus_out", 39, tr_out[39], REG_SECONDS);
        chk1("b2b.req_ready", 39, tr_rdy[39], 1'b0);
        chk1("b2b.busy", 39, tr_busy[39], 1'b1);
        repeat (45) @(negedge clk);
        chk1("b2b.drain_ready", 0, bus_a.req_ready, 1'b1);

        // Reset during read D_STROBE aborts the transaction
        run_txn(1'b0, 1'b0, REG_HOURS, 8'h00, 8'h33, 40, 1'b0, 8'h00, 22);
        check_default("rstrd", 1'b0, REG_HOURS, 8'h00, 8'h59, 8'h33, 22);
        for (int k = 23; k <= 40; k++) begin
            chk1("rstrd.cs_n", k, tr_cs[k], 1'b1);
            chk1("rstrd.rd_n", k, tr_rd[k], 1'b1);
            chk1("rstrd.bus_oe", k, tr_oe[k], 1'b0);
            chk1("rstrd.rsp_valid", k, tr_rv[k], 1'b0);
            chk8("rstrd.rsp_rdata", k, tr_rdata[k], 8'h00);
            chk1("rstrd.req_ready", k, tr_rdy[k], 1'b1);
            chk1("rstrd.busy", k, tr_busy[k], 1'b0);
        end

        // Short-timing instance, write
        run_txn(1'b1, 1'b1, REG_CONTROL, 8'h07, 8'h00, 16, 1'b0, 8'h00, 0);
        for (int k = 1; k <= 16; k++) begin
            chk1("ovr.cs_n", k, tr_cs[k], !((k >= 1 && k <= 6) || (k >= 8 && k <= 13)));
            chk1("ovr.wr_n", k, tr_wr[k], !((k >= 3 && k <= 5) || (k >= 10 && k <= 12)));
            chk1("ovr.rd_n", k, tr_rd[k], 1'b1);
            chk1("ovr.rsp_valid", k, tr_rv[k], k == 14);
            chk1("ovr.req_ready", k, tr_rdy[k], k >= 15);
            chk1("ovr.busy", k, tr_busy[k], k <= 14);
            if (k <= 6)            chk8("ovr.bus_out", k, tr_out[k], REG_CONTROL);
            if (k >= 8 && k <= 13) chk8("ovr.bus_out", k, tr_out[k], 8'h07);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
